instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 9 +
 rtl/instr_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction stream handshake between the sequencer and its consumer.
interface instr_sequencer_if;
  logic [16:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/instr_sequencer.sv
// Plays a CPU-loaded program out of a synchronous RAM as an instruction stream,
// looping over it a fixed number of passes with abort and halt reporting.
module instr_sequencer #(
  parameter int unsigned PROG_DEPTH = 256,
  parameter int unsigned AW         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_wr_en,
  input  logic [AW-1:0]            prog_wr_addr,
  input  logic [16:0]              prog_wr_data,
  input  logic [AW:0]              prog_len,
  input  logic [15:0]              loop_count,
  input  logic                     start,
  input  logic                     abort,
  instr_sequencer_if.master        instr_axis,
  output logic                     halt,
  output logic                     busy,
  output logic [15:0]              pass_cnt,
  output logic                     wr_err
);

  localparam logic [AW:0] DepthLen = (AW+1)'(PROG_DEPTH);

  typedef enum logic [2:0] {StIdle, StPrime, StStream, StDrain, StDone} state_e;

  logic [16:0]   mem [PROG_DEPTH];
  logic [16:0]   mem_q;

  state_e        state_q;
  logic          start_q;
  logic [AW-1:0] last_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] beat_addr_q;
  logic [15:0]   fetch_rem_q;
  logic [15:0]   pass_rem_q;
  logic          fetch_done_q;
  logic          rd_pend_q;
  logic          skid_vld_q;
  logic [16:0]   skid_q;
  logic          tvalid_q;
  logic [16:0]   tdata_q;
  logic          halt_q;
  logic          busy_q;
  logic          wr_err_q;
  logic [15:0]   pass_cnt_q;

  logic [AW:0]   len_min;
  logic [15:0]   n_min;
  logic          pop;
  logic          final_beat;
  logic [1:0]    occ_net;
  logic          rd_en;

  always_comb begin
    len_min    = (prog_len > DepthLen) ? DepthLen : prog_len;
    n_min      = (loop_count == 16'd0) ? 16'd1 : loop_count;
    pop        = tvalid_q & instr_axis.tready;
    final_beat = pop & (beat_addr_q == last_q) & (pass_rem_q == 16'd1);
    // Entries that still need a slot (output + skid) after this edge; a new read
    // may only be issued if it is guaranteed a landing place next cycle.
    occ_net    = 2'(tvalid_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(pop);
    rd_en      = ~abort & ((state_q == StPrime) |
                           ((state_q == StStream) & ~fetch_done_q & (occ_net < 2'd2)));
  end

  always_ff @(posedge clk) begin
    if (prog_wr_en && !busy_q) mem[prog_wr_addr] <= prog_wr_data;
    if (rd_en) mem_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      last_q       <= '0;
      rd_addr_q    <= '0;
      beat_addr_q  <= '0;
      fetch_rem_q  <= '0;
      pass_rem_q   <= '0;
      fetch_done_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_q       <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      halt_q       <= 1'b0;
      busy_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      pass_cnt_q   <= '0;
    end else begin
      start_q <= start;
      if (prog_wr_en && busy_q) wr_err_q <= 1'b1;

      if (rd_en) begin
        if (rd_addr_q == last_q) begin
          rd_addr_q   <= '0;
          fetch_rem_q <= fetch_rem_q - 16'd1;
          if (fetch_rem_q == 16'd1) fetch_done_q <= 1'b1;
        end else begin
          rd_addr_q <= rd_addr_q + AW'(1);
        end
      end

      if (pop) begin
        if (beat_addr_q == last_q) begin
          beat_addr_q <= '0;
          pass_rem_q  <= pass_rem_q - 16'd1;
          if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
        end else begin
          beat_addr_q <= beat_addr_q + AW'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start && !start_q) begin
            last_q       <= AW'(len_min - (AW+1)'(1));
            rd_addr_q    <= '0;
            beat_addr_q  <= '0;
            fetch_rem_q  <= n_min;
            pass_rem_q   <= n_min;
            fetch_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            tvalid_q     <= 1'b0;
            pass_cnt_q   <= '0;
            wr_err_q     <= 1'b0;
            if (len_min == '0) begin
              halt_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              halt_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StPrime;
            end
          end
        end
        StPrime, StStream: begin
          rd_pend_q <= rd_en;
          if (final_beat) begin
            rd_pend_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            tvalid_q   <= 1'b0;
            halt_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end else if (abort) begin
            // Prefetched data is discarded; only a presented beat is honoured.
            rd_pend_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            if (tvalid_q && !instr_axis.tready) begin
              state_q <= StDrain;
            end else begin
              tvalid_q <= 1'b0;
              halt_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StDone;
            end
          end else begin
            if (!tvalid_q || instr_axis.tready) begin
              if (skid_vld_q) begin
                tdata_q    <= skid_q;
                tvalid_q   <= 1'b1;
                skid_vld_q <= rd_pend_q;
                skid_q     <= mem_q;
              end else if (rd_pend_q) begin
                tdata_q  <= mem_q;
                tvalid_q <= 1'b1;
              end else begin
                tvalid_q <= 1'b0;
              end
            end else if (rd_pend_q) begin
              skid_q     <= mem_q;
              skid_vld_q <= 1'b1;
            end
            state_q <= StStream;
          end
        end
        StDrain: begin
          if (instr_axis.tready) begin
            tvalid_q <= 1'b0;
            halt_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (!start) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_axis.tdata  = tdata_q;
  assign instr_axis.tvalid = tvalid_q;
  assign halt              = halt_q;
  assign busy              = busy_q;
  assign pass_cnt          = pass_cnt_q;
  assign wr_err            = wr_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer: streaming, backpressure, abort,
// zero-length, loop-count floor, write-while-busy and mid-run reset.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_wr_en;
  logic [7:0]  prog_wr_addr;
  logic [16:0] prog_wr_data;
  logic [8:0]  prog_len;
  logic [15:0] loop_count;
  logic        start;
  logic        abort;
  logic        halt;
  logic        busy;
  logic [15:0] pass_cnt;
  logic        wr_err;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] prog_words [4];

  instr_sequencer_if axis ();

  instr_sequencer #(.PROG_DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .prog_len     (prog_len),
    .loop_count   (loop_count),
    .start        (start),
    .abort        (abort),
    .instr_axis   (axis),
    .halt         (halt),
    .busy         (busy),
    .pass_cnt     (pass_cnt),
    .wr_err       (wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [16:0] d);
    prog_wr_en = 1'b1; prog_wr_addr = a; prog_wr_data = d;
    tick();
    prog_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 17'h0 || halt !== 1'b0 || busy !== 1'b0 ||
        pass_cnt !== 16'h0 || wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h halt=%b busy=%b pass=%0d wr_err=%b, want all 0",
               axis.tvalid, axis.tdata, halt, busy, pass_cnt, wr_err);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) write_word(8'(i), prog_words[i]);
  endtask

  task automatic test_basic();
    bit exp_v;
    tick();
    prog_len = 9'd3; loop_count = 16'd2; axis.tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      start = 1'b0;
      exp_v = (k >= 2 && k <= 7);
      n_vec++;
      if (axis.tvalid !== exp_v) begin
        n_err++;
        $display("FAIL basic_tvalid k=%0d: got %b, want %b", k, axis.tvalid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (axis.tdata !== prog_words[(k-2)%3]) begin
          n_err++;
          $display("FAIL basic_tdata k=%0d: got %h, want %h", k, axis.tdata, prog_words[(k-2)%3]);
        end
      end
      n_vec++;
      if (halt !== (k >= 8)) begin
        n_err++;
        $display("FAIL basic_halt k=%0d: got %b, want %b", k, halt, (k >= 8));
      end
      if (k == 1) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b, want 1", busy); end
      end
    end
    n_vec++;
    if (pass_cnt !== 16'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: got pass=%0d busy=%b, want pass=2 busy=0", pass_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    int nb;
    bit held_v, done;
    logic [16:0] held_d;
    pat = 16'b1011_0010_1101_1001;
    nb = 0; held_v = 0; done = 0; held_d = '0;
    tick();
    prog_len = 9'd3; loop_count = 16'd2; axis.tready = 1'b0; start = 1'b1;
    for (int k = 0; k < 80 && !done; k++) begin
      tick();
      start = 1'b0;
      axis.tready = pat[k%16];
      if (held_v) begin
        n_vec++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== held_d) begin
          n_err++;
          $display("FAIL bp_stall_hold k=%0d: got tvalid=%b tdata=%h, want 1/%h",
                   k, axis.tvalid, axis.tdata, held_d);
        end
      end
      held_v = 0;
      if (axis.tvalid === 1'b1 && axis.tready) begin
        n_vec++;
        if (nb >= 6 || axis.tdata !== prog_words[nb%3]) begin
          n_err++;
          $display("FAIL bp_beat #%0d: got %h, want %h", nb, axis.tdata, prog_words[nb%3]);
        end
        nb++;
      end else if (axis.tvalid === 1'b1) begin
        held_v = 1; held_d = axis.tdata;
      end
      n_vec++;
      if (halt === 1'b1 && axis.tvalid === 1'b1) begin
        n_err++;
        $display("FAIL bp_halt_tvalid k=%0d: got both 1, want exclusive", k);
      end
      if (halt === 1'b1) done = 1;
    end
    n_vec++;
    if (!done || nb != 6 || pass_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL bp_end: got halted=%0d beats=%0d pass=%0d, want 1/6/2", done, nb, pass_cnt);
    end
    axis.tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (axis.tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_after_halt k=%0d: got tvalid=%b, want 0", k, axis.tvalid);
      end
    end
  endtask

  task automatic test_zero_len();
    tick();
    prog_len = 9'd0; loop_count = 16'd5; axis.tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (halt !== 1'b1 || busy !== 1'b0 || axis.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: got halt=%b busy=%b tvalid=%b, want 1/0/0", halt, busy, axis.tvalid);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (axis.tvalid !== 1'b0 || halt !== 1'b1) begin
        n_err++;
        $display("FAIL zero_len_quiet k=%0d: got tvalid=%b halt=%b, want 0/1", k, axis.tvalid, halt);
      end
    end
  endtask

  task automatic test_loop_zero();
    int nb;
    nb = 0;
    tick();
    prog_len = 9'd4; loop_count = 16'd0; axis.tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      start = 1'b0;
      if (axis.tvalid === 1'b1) begin
        n_vec++;
        if (nb >= 4 || axis.tdata !== prog_words[nb%4]) begin
          n_err++;
          $display("FAIL loop0_beat #%0d: got %h, want %h", nb, axis.tdata, prog_words[nb%4]);
        end
        nb++;
      end
    end
    n_vec++;
    if (nb != 4 || pass_cnt !== 16'd1 || halt !== 1'b1) begin
      n_err++;
      $display("FAIL loop0_end: got beats=%0d pass=%0d halt=%b, want 4/1/1", nb, pass_cnt, halt);
    end
  endtask

  task automatic test_abort();
    tick();
    prog_len = 9'd3; loop_count = 16'd2; axis.tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      start = 1'b0;
      axis.tready = !(k >= 4 && k <= 8);
      abort = (k >= 4 && k <= 5);
      if (k >= 2 && k <= 9) begin
        n_vec++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== prog_words[(k >= 4) ? 2 : k-2] || halt !== 1'b0) begin
          n_err++;
          $display("FAIL abort_hold k=%0d: got tvalid=%b tdata=%h halt=%b, want 1/%h/0",
                   k, axis.tvalid, axis.tdata, halt, prog_words[(k >= 4) ? 2 : k-2]);
        end
      end else if (k >= 10) begin
        n_vec++;
        if (axis.tvalid !== 1'b0 || halt !== 1'b1) begin
          n_err++;
          $display("FAIL abort_end k=%0d: got tvalid=%b halt=%b, want 0/1", k, axis.tvalid, halt);
        end
      end
    end
    abort = 1'b0;
    n_vec++;
    if (pass_cnt !== 16'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pass: got pass=%0d busy=%b, want 1/0", pass_cnt, busy);
    end
  endtask

  task automatic test_wr_err();
    int nb;
    nb = 0;
    tick();
    prog_len = 9'd3; loop_count = 16'd1; axis.tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      start = 1'b0;
      prog_wr_en = (k == 1); prog_wr_addr = 8'd0; prog_wr_data = 17'h1FFFF;
      if (k == 2) begin
        n_vec++;
        if (wr_err !== 1'b1) begin n_err++; $display("FAIL wr_err_set: got %b, want 1", wr_err); end
      end
      if (axis.tvalid === 1'b1) begin
        n_vec++;
        if (nb >= 3 || axis.tdata !== prog_words[nb%3]) begin
          n_err++;
          $display("FAIL wr_err_beat #%0d: got %h, want %h", nb, axis.tdata, prog_words[nb%3]);
        end
        nb++;
      end
    end
    prog_wr_en = 1'b0;
    n_vec++;
    if (nb != 3 || wr_err !== 1'b1 || halt !== 1'b1) begin
      n_err++;
      $display("FAIL wr_err_sticky: got beats=%0d wr_err=%b halt=%b, want 3/1/1", nb, wr_err, halt);
    end
    nb = 0;
    prog_len = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_clear: got %b, want 0", wr_err); end
    for (int k = 1; k < 6; k++) begin
      tick();
      if (axis.tvalid === 1'b1) begin
        n_vec++;
        if (nb >= 1 || axis.tdata !== prog_words[0]) begin
          n_err++;
          $display("FAIL mem_unchanged #%0d: got %h, want %h", nb, axis.tdata, prog_words[0]);
        end
        nb++;
      end
    end
    n_vec++;
    if (nb != 1) begin n_err++; $display("FAIL mem_unchanged_count: got %0d beats, want 1", nb); end
  endtask

  task automatic test_reset_mid();
    tick();
    prog_len = 9'd3; loop_count = 16'd2; axis.tready = 1'b1; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      start = 1'b0;
    end
    n_vec++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== prog_words[1]) begin
      n_err++;
      $display("FAIL rst_mid_pre: got tvalid=%b tdata=%h, want 1/%h", axis.tvalid, axis.tdata, prog_words[1]);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 17'h0 || halt !== 1'b0 || busy !== 1'b0 ||
        pass_cnt !== 16'h0 || wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got tvalid=%b tdata=%h halt=%b busy=%b pass=%0d wr_err=%b, want all 0",
               axis.tvalid, axis.tdata, halt, busy, pass_cnt, wr_err);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (axis.tvalid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_quiet k=%0d: got tvalid=%b busy=%b, want 0/0", k, axis.tvalid, busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog_words[0] = 17'h00001;
    prog_words[1] = 17'h00002;
    prog_words[2] = 17'h00004;
    prog_words[3] = 17'h10008;
    rst = 1'b1; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    prog_len = '0; loop_count = '0; start = 1'b0; abort = 1'b0; axis.tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_loop_zero();
    test_abort();
    test_wr_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
